hold_confirm_timer: RTL and testbench
=====================================

Name: hold_confirm_timer

Overview:
- Parametrised hold-to-confirm countdown. Generalises the fixed 5-tick save counter.
- Counts qualified `tick` strobes while `en` (button held) stays high, then fires a `done` pulse.
- Optionally auto-repeats `done` while the button is still held, e.g. for fast-increment of hour/minute fields.
- Adds synchronous abort (`clr`) with release-to-rearm lockout.
- Sits between the debounced button/mode logic and the time/alarm setting registers.

Parameters:
- CNT_W, 3: width of the countdown and repeat counters.
- HOLD_TICKS, 5: ticks required before the first `done`. Legal range 1 .. 2^CNT_W-1.
- REPEAT_EN, 0: 0 = one-shot; 1 = repeat `done` while held.
- REPEAT_TICKS, 1: ticks between repeat pulses when REPEAT_EN=1. Legal range 1 .. 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  hold request (debounced button level)
- tick  in  1  single-cycle time-base strobe (e.g. 1 Hz enable); not a clock
- clr  in  1  synchronous abort
- ticks_left  out  CNT_W  ticks remaining before first `done`
- busy  out  1  countdown in progress
- done  out  1  single-cycle confirm pulse
- held  out  1  level, high after first `done` while still held

Behaviour:
- Reset values: state IDLE, ticks_left=HOLD_TICKS, rep_cnt=0, done=0. busy and held are 0 by decode.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Decoded outputs: busy=(state==COUNT); held=(state==FIRED).
- Priority each edge: clr > en low > tick.
- IDLE:
  - ticks_left=HOLD_TICKS.
  - en=1 -> COUNT.
  - A tick in the same cycle as this entry is NOT counted.
- COUNT, en=1, tick=1:
  - If ticks_left>1: ticks_left-=1.
  - If ticks_left==1: ticks_left<=0, done<=1, rep_cnt<=0, -> FIRED. `done` is visible the cycle after that tick edge.
- COUNT, en=1, tick=0: hold all values.
- FIRED:
  - ticks_left stays 0.
  - REPEAT_EN=0: no further pulses.
  - REPEAT_EN=1: each tick increments rep_cnt. When rep_cnt==REPEAT_TICKS-1 and tick=1: done<=1, rep_cnt<=0.
- en=0 in COUNT or FIRED: -> IDLE next edge, ticks_left<=HOLD_TICKS, done<=0. No partial credit is kept across releases.
- clr=1 in any state: -> LOCKOUT, ticks_left<=HOLD_TICKS, done<=0, rep_cnt<=0.
- LOCKOUT:
  - busy=0, held=0; en and tick are ignored.
  - Leaves to IDLE only on an edge where en=0 and clr=0. The user must release and re-press.
- done is never high for two consecutive cycles. tick is assumed to be at most 1 cycle wide; a 2-cycle tick counts twice.
- Simultaneous events:
  - Final tick with en=0 -> IDLE, no done.
  - Final tick with clr=1 -> LOCKOUT, no done.
  - Repeat tick with en falling -> no done.
- HOLD_TICKS=1: the first counted tick fires.
- REPEAT_TICKS=1: done pulses on every tick in FIRED.
- Async reset mid-count or mid-FIRED: immediate return to reset values, no done.
- Counters never wrap: ticks_left is only decremented when >1, and rep_cnt is bounded by REPEAT_TICKS.

Test Plan:
- Default params; en=1 held, 6 ticks 10 cycles apart.
  - ticks_left steps 5,4,3,2,1,0.
  - done is 1 for exactly one cycle after the 5th tick; held=1 afterwards.
  - 6th tick gives no done.
- en=1 for 3 ticks, en=0, en=1 again.
  - ticks_left returns to 5 and busy=0 after release.
  - A further 5 ticks are needed for done.
- en rises in the same cycle as a tick.
  - That tick is ignored; done comes after 5 subsequent ticks.
- REPEAT_EN=1, REPEAT_TICKS=2; hold for 9 ticks.
  - done after tick 5, 7, 9 (3 pulses).
  - Release at tick 10 with a tick present gives no done.
- clr at ticks_left=2 with en still high.
  - -> LOCKOUT: busy=0, ticks_left=5, no done on further ticks.
  - After en=0 then en=1, counting restarts from 5.
- rst_n asserted mid-count (ticks_left=3), then concurrent final-tick+en=0 and final-tick+clr.
  - Outputs return to reset values asynchronously.
  - Neither concurrent case produces done.

Source files
------------

// File: rtl/hold_confirm_timer_if.sv
// Handshake bundle between the button/mode logic and the hold-to-confirm timer.
// The master drives the hold request, time-base strobe and abort; the slave reports progress.
interface hold_confirm_timer_if #(
  parameter int unsigned CNT_W = 3
) ();

  logic             en;
  logic             tick;
  logic             clr;
  logic [CNT_W-1:0] ticks_left;
  logic             busy;
  logic             done;
  logic             held;

  modport master (
    output en,
    output tick,
    output clr,
    input  ticks_left,
    input  busy,
    input  done,
    input  held
  );

  modport slave (
    input  en,
    input  tick,
    input  clr,
    output ticks_left,
    output busy,
    output done,
    output held
  );

endinterface

// File: rtl/hold_confirm_timer.sv
// Hold-to-confirm countdown: counts ticks while the button is held, pulses done once the hold
// completes, optionally auto-repeats, and locks out after an abort until the button is released.
module hold_confirm_timer #(
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned HOLD_TICKS   = 5,
  parameter bit          REPEAT_EN    = 1'b0,
  parameter int unsigned REPEAT_TICKS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hold_confirm_timer_if.slave    bus_io
);

  localparam logic [CNT_W-1:0] HoldInit = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] One      = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StFired,
    StLockout
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] ticks_left_q;
  logic [CNT_W-1:0] rep_cnt_q;
  logic             done_q;

  // Priority per edge: clr, then release, then tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ticks_left_q <= HoldInit;
      rep_cnt_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus_io.clr) begin
        state_q      <= StLockout;
        ticks_left_q <= HoldInit;
        rep_cnt_q    <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            // A tick coinciding with the press is deliberately not counted.
            ticks_left_q <= HoldInit;
            if (bus_io.en) begin
              state_q <= StCount;
            end
          end
          StCount: begin
            if (!bus_io.en) begin
              state_q      <= StIdle;
              ticks_left_q <= HoldInit;
            end else if (bus_io.tick) begin
              if (ticks_left_q > One) begin
                ticks_left_q <= ticks_left_q - One;
              end else begin
                ticks_left_q <= '0;
                done_q       <= 1'b1;
                rep_cnt_q    <= '0;
                state_q      <= StFired;
              end
            end
          end
          StFired: begin
            if (!bus_io.en) begin
              state_q      <= StIdle;
              ticks_left_q <= HoldInit;
            end else if (REPEAT_EN && bus_io.tick) begin
              if (rep_cnt_q == RepLast) begin
                done_q    <= 1'b1;
                rep_cnt_q <= '0;
              end else begin
                rep_cnt_q <= rep_cnt_q + One;
              end
            end
          end
          StLockout: begin
            // Leaving needs a release; clr is already known low here.
            if (!bus_io.en) begin
              state_q <= StIdle;
            end
          end
          default: begin
            state_q      <= StIdle;
            ticks_left_q <= HoldInit;
          end
        endcase
      end
    end
  end

  assign bus_io.ticks_left = ticks_left_q;
  assign bus_io.done       = done_q;
  assign bus_io.busy       = (state_q == StCount);
  assign bus_io.held       = (state_q == StFired);

endmodule

// File: tb/tb_hold_confirm_timer.sv
// Bench for hold_confirm_timer: one-shot and repeating instances share stimulus and are checked
// every cycle against a press-duration model, plus directed literal checks.
module tb_hold_confirm_timer;

  localparam int HOLD = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic tick = 1'b0;
  logic clr = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  hold_confirm_timer_if #(.CNT_W(3)) if0 ();
  hold_confirm_timer_if #(.CNT_W(3)) if1 ();

  assign if0.en = en;
  assign if0.tick = tick;
  assign if0.clr = clr;
  assign if1.en = en;
  assign if1.tick = tick;
  assign if1.clr = clr;

  hold_confirm_timer #(
    .CNT_W(3), .HOLD_TICKS(5), .REPEAT_EN(1'b0), .REPEAT_TICKS(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus_io(if0)
  );

  hold_confirm_timer #(
    .CNT_W(3), .HOLD_TICKS(5), .REPEAT_EN(1'b1), .REPEAT_TICKS(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus_io(if1)
  );

  always #5 clk = ~clk;

  // Model: phase 0 released, 1 pressed (n = ticks counted since press), 2 locked out.
  int rep_en[2] = '{0, 1};
  int rep_t[2]  = '{1, 2};
  int phase[2]  = '{0, 0};
  int n[2]      = '{0, 0};
  bit mdone[2]  = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        phase[k] = 0;
        n[k] = 0;
        mdone[k] = 1'b0;
      end else begin
        mdone[k] = 1'b0;
        if (clr) begin
          phase[k] = 2;
          n[k] = 0;
        end else if (phase[k] == 0) begin
          if (en) begin
            phase[k] = 1;
            n[k] = 0;
          end
        end else if (phase[k] == 1) begin
          if (!en) begin
            phase[k] = 0;
          end else if (tick) begin
            n[k]++;
            if (n[k] == HOLD) mdone[k] = 1'b1;
            else if (n[k] > HOLD && rep_en[k] != 0 && ((n[k] - HOLD) % rep_t[k]) == 0)
              mdone[k] = 1'b1;
          end
        end else begin
          if (!en) phase[k] = 0;
        end
      end
    end
  end

  function automatic int exp_ticks(input int k);
    if (phase[k] != 1) return HOLD;
    return (n[k] >= HOLD) ? 0 : HOLD - n[k];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m0_ticks_left", 32'(if0.ticks_left), 32'(exp_ticks(0)));
      chk("m0_busy", 32'(if0.busy), 32'(phase[0] == 1 && n[0] < HOLD));
      chk("m0_held", 32'(if0.held), 32'(phase[0] == 1 && n[0] >= HOLD));
      chk("m0_done", 32'(if0.done), 32'(mdone[0]));
      chk("m1_ticks_left", 32'(if1.ticks_left), 32'(exp_ticks(1)));
      chk("m1_busy", 32'(if1.busy), 32'(phase[1] == 1 && n[1] < HOLD));
      chk("m1_held", 32'(if1.held), 32'(phase[1] == 1 && n[1] >= HOLD));
      chk("m1_done", 32'(if1.done), 32'(mdone[1]));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Tick sampled on one edge; on return the outputs reflect that edge.
  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  int tl_tab[6] = '{4, 3, 2, 1, 0, 0};
  int pulses0;
  int pulses1;

  initial begin
    #12;
    chk("rst_ticks_left", 32'(if0.ticks_left), 32'd5);
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_held", 32'(if0.held), 32'd0);
    chk("rst_done", 32'(if0.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // One-shot and repeat under a long hold.
    en = 1'b1;
    cyc(1);
    chk("t1_busy_after_press", 32'(if0.busy), 32'd1);
    chk("t1_ticks_start", 32'(if0.ticks_left), 32'd5);
    pulses0 = 0;
    pulses1 = 0;
    for (int i = 1; i <= 9; i++) begin
      cyc(8);
      pulse_tick();
      if (i <= 6) chk("t1_ticks_step", 32'(if0.ticks_left), 32'(tl_tab[i-1]));
      if (i <= 6) chk("t1_done_at_5th", 32'(if0.done), 32'(i == 5));
      pulses0 += int'(if0.done);
      pulses1 += int'(if1.done);
      @(negedge clk);
      chk("t1_done_one_cycle", 32'(if0.done | if1.done), 32'd0);
    end
    chk("t1_held", 32'(if0.held), 32'd1);
    chk("t1_oneshot_pulses", 32'(pulses0), 32'd1);
    chk("t1_repeat_pulses", 32'(pulses1), 32'd3);
    @(negedge clk);
    en = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("t1_release_tick_no_done", 32'(if1.done), 32'd0);
    chk("t1_release_held", 32'(if1.held), 32'd0);

    // Partial hold earns no credit.
    cyc(2);
    en = 1'b1;
    repeat (3) begin cyc(3); pulse_tick(); end
    chk("t2_partial", 32'(if0.ticks_left), 32'd2);
    en = 1'b0;
    cyc(1);
    chk("t2_release_ticks", 32'(if0.ticks_left), 32'd5);
    chk("t2_release_busy", 32'(if0.busy), 32'd0);
    en = 1'b1;
    repeat (4) begin cyc(3); pulse_tick(); chk("t2_no_early_done", 32'(if0.done), 32'd0); end
    cyc(3);
    pulse_tick();
    chk("t2_done_after_5", 32'(if0.done), 32'd1);
    en = 1'b0;
    cyc(2);

    // Tick coinciding with press is ignored.
    en = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("t3_press_tick_ignored", 32'(if0.ticks_left), 32'd5);
    repeat (4) begin cyc(3); pulse_tick(); chk("t3_no_early_done", 32'(if0.done), 32'd0); end
    cyc(3);
    pulse_tick();
    chk("t3_done", 32'(if0.done), 32'd1);
    en = 1'b0;
    cyc(2);

    // Abort at ticks_left=2, then lockout until release.
    en = 1'b1;
    repeat (3) begin cyc(3); pulse_tick(); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t4_clr_busy", 32'(if0.busy), 32'd0);
    chk("t4_clr_ticks", 32'(if0.ticks_left), 32'd5);
    repeat (6) begin cyc(2); pulse_tick(); chk("t4_lockout_no_done", 32'(if0.done), 32'd0); end
    chk("t4_lockout_busy", 32'(if0.busy), 32'd0);
    en = 1'b0;
    cyc(1);
    en = 1'b1;
    cyc(1);
    chk("t4_rearm_busy", 32'(if0.busy), 32'd1);
    pulse_tick();
    chk("t4_rearm_count", 32'(if0.ticks_left), 32'd4);
    en = 1'b0;
    cyc(2);

    // Async reset mid-count.
    en = 1'b1;
    repeat (2) begin cyc(2); pulse_tick(); end
    chk("t5_pre_reset", 32'(if0.ticks_left), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ticks", 32'(if0.ticks_left), 32'd5);
    chk("t5_async_busy", 32'(if0.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    cyc(2);

    // Final tick with release, then final tick with clr.
    en = 1'b1;
    repeat (4) begin cyc(2); pulse_tick(); end
    en = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("t5_final_release_done", 32'(if0.done), 32'd0);
    chk("t5_final_release_ticks", 32'(if0.ticks_left), 32'd5);
    en = 1'b1;
    repeat (4) begin cyc(2); pulse_tick(); end
    clr = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tick = 1'b0;
    chk("t5_final_clr_done", 32'(if0.done), 32'd0);
    chk("t5_final_clr_busy", 32'(if0.busy), 32'd0);
    en = 1'b0;
    cyc(2);

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 24) == 0) en = ~en;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rand_async_ticks", 32'(if1.ticks_left), 32'd5);
        chk("rand_async_done", 32'(if1.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
